// File: rtl/md_sched.sv
// Sequencing controller for the E-stage multiply/divide unit: decides when an
// operation starts, when its result commits to HI/LO, and when D must stall.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       op_valid,
    input  logic [3:0] op,
    input  logic       d_md,
    output logic       start,
    output logic [3:0] op_q,
    output logic       busy,
    output logic       commit,
    output logic       wr_hi,
    output logic       wr_lo,
    output logic       stall,
    output logic [3:0] cnt,
    output logic       err,
    output logic       dbg_state
);

    // Handshake: E offers (op_valid, op) for one cycle only; there is no
    // back-pressure to E, so an offer made while BUSY is dropped and flagged.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] L_MULT   = 4'(MULT_CYCLES);
    localparam logic [3:0] L_DIV    = 4'(DIV_CYCLES);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_op_q;
    logic [3:0] w_op_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_err;
    logic       w_err_nxt;
    logic       w_take;
    logic       w_md_op;
    logic       w_mt_op;
    logic       w_issue;

    assign w_take  = op_valid & ~req;
    assign w_md_op = (op >= OP_MULT) && (op <= OP_DIVU);
    assign w_mt_op = (op == OP_MTHI) || (op == OP_MTLO);
    assign w_issue = w_take & w_md_op & (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_op_q  <= 4'd0;
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op_q  <= w_op_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op_q;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        start       = 1'b0;
        commit      = 1'b0;
        wr_hi       = 1'b0;
        wr_lo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_take && w_md_op) begin
                    start       = 1'b1;
                    w_state_nxt = S_BUSY;
                    w_op_nxt    = op;
                    w_cnt_nxt   = (op <= OP_MULTU) ? L_MULT : L_DIV;
                end else if (w_take && w_mt_op) begin
                    wr_hi = (op == OP_MTHI);
                    wr_lo = (op == OP_MTLO);
                end
            end
            S_BUSY: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (w_take && (w_md_op || w_mt_op)) begin
                    w_err_nxt = 1'b1;
                end
                // A reset on the final cycle drops the commit entirely.
                if (r_cnt == 4'd1) begin
                    commit      = reset;
                    w_state_nxt = S_IDLE;
                    w_op_nxt    = 4'd0;
                    w_cnt_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy      = (r_state == S_BUSY);
    assign stall     = d_md & (busy | w_issue);
    assign op_q      = r_op_q;
    assign cnt       = r_cnt;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_md_sched.sv
// Randomised and directed bench for md_sched; expected outputs per cycle come
// from a timeline model (issue cycle + latency) held in the bench.
module tb_md_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       op_valid;
  logic [3:0] op;
  logic       d_md;
  logic       start;
  logic [3:0] op_q;
  logic       busy;
  logic       commit;
  logic       wr_hi;
  logic       wr_lo;
  logic       stall;
  logic [3:0] cnt;
  logic       err;
  logic       dbg_state;

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .req(req), .op_valid(op_valid), .op(op),
    .d_md(d_md), .start(start), .op_q(op_q), .busy(busy), .commit(commit),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .stall(stall), .cnt(cnt), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // expected vector: start, op_q[4], busy, commit, wr_hi, wr_lo, stall, cnt[4], err
  logic [14:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int mon_cyc  = 0;

  // reference model: one owned operation, described by its issue cycle
  int         cyc       = 0;
  bit         own       = 0;
  int         issue_cyc = 0;
  int         lat       = 0;
  logic [3:0] own_op    = 4'd0;
  bit         m_err     = 0;

  task automatic drive(input logic rst, input logic rq, input logic ov,
                       input logic [3:0] o, input logic dm);
    bit         is_md, is_mt, take, iss, mt, cmt, stl;
    logic [3:0] e_cnt;
    reset = rst; req = rq; op_valid = ov; op = o; d_md = dm;
    is_md = (o >= 4'd1) && (o <= 4'd4);
    is_mt = (o == 4'd5) || (o == 4'd6);
    take  = ov && !rq;
    iss   = take && is_md && !own;
    mt    = take && is_mt && !own;
    cmt   = own && (cyc == issue_cyc + lat) && rst;
    stl   = dm && (own || iss);
    e_cnt = own ? 4'(issue_cyc + lat + 1 - cyc) : 4'd0;
    exp_q.push_back({iss, (own ? own_op : 4'd0), own, cmt,
                     (mt && o == 4'd5), (mt && o == 4'd6), stl, e_cnt, m_err});
    @(posedge clk);
    if (!rst) begin
      own   = 0;
      m_err = 0;
    end else begin
      if (own && take && (is_md || is_mt)) m_err = 1;
      if (own && cyc == issue_cyc + lat) own = 0;
      else if (iss) begin
        own       = 1;
        issue_cyc = cyc;
        own_op    = o;
        lat       = (o <= 4'd2) ? MULT_N : DIV_N;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic dm);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 4'd0, dm);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, mon_cyc, act, exp);
    end
  endtask

  // monitor: pop one expectation per cycle once inputs have settled
  always @(negedge clk) begin
    logic [14:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("start",  {3'b0, start},  {3'b0, e[14]});
      chk("op_q",   op_q,           e[13:10]);
      chk("busy",   {3'b0, busy},   {3'b0, e[9]});
      chk("commit", {3'b0, commit}, {3'b0, e[8]});
      chk("wr_hi",  {3'b0, wr_hi},  {3'b0, e[7]});
      chk("wr_lo",  {3'b0, wr_lo},  {3'b0, e[6]});
      chk("stall",  {3'b0, stall},  {3'b0, e[5]});
      chk("cnt",    cnt,            e[4:1]);
      chk("err",    {3'b0, err},    {3'b0, e[0]});
      mon_cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req = 1'b0; op_valid = 1'b0; op = 4'd0; d_md = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset-held cycles
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    // MULT with MFLO waiting in D
    drive(1'b1, 1'b0, 1'b1, 4'd1, 1'b1);
    idle(7, 1'b1);
    // DIVU then DIV back-to-back after commit
    drive(1'b1, 1'b0, 1'b1, 4'd4, 1'b0);
    idle(10, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'd3, 1'b1);
    idle(11, 1'b0);
    // req suppresses issue; req mid-DIV has no effect
    drive(1'b1, 1'b1, 1'b1, 4'd3, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 4'd3, 1'b0);
    idle(2, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    idle(8, 1'b0);
    // reset while cnt==1 drops the commit
    drive(1'b1, 1'b0, 1'b1, 4'd2, 1'b0);
    idle(4, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    idle(2, 1'b0);
    // MTHI while busy sets err; MTLO in idle writes
    drive(1'b1, 1'b0, 1'b1, 4'd1, 1'b0);
    idle(1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
    idle(5, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'd6, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'd5, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 4'd8, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    idle(1, 1'b0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
